// File: rtl/instr_decode_stage_if.sv
// Fetch <-> decode bundle for instr_decode_stage: instruction/address in,
// fetch control and the ID/EX register contents out.
interface instr_decode_stage_if;
    // ins/pc_in are presented every cycle with no valid qualifier. While stall
    // is high, fetch keeps its PC and re-presents the same word (stall_pm).
    // While pc_mux_sel is high, the next address fetch uses is jmp_loc.
    // Neither side applies any other backpressure.
    logic [31:0] ins;
    logic [15:0] pc_in;
    logic        stall;
    logic        stall_pm;
    logic        pc_mux_sel;
    logic [15:0] jmp_loc;
    logic        ex_valid;
    logic [5:0]  ex_op;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [15:0] ex_imm;
    logic [15:0] ex_pc;
    logic        ex_wb;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        dbg_state;

    modport slave (
        input  ins, pc_in,
        output stall, stall_pm, pc_mux_sel, jmp_loc,
        output ex_valid, ex_op, ex_rd, ex_rs1, ex_rs2, ex_imm, ex_pc,
        output ex_wb, ex_mem_rd, ex_mem_wr, dbg_state
    );

    modport master (
        output ins, pc_in,
        input  stall, stall_pm, pc_mux_sel, jmp_loc,
        input  ex_valid, ex_op, ex_rd, ex_rs1, ex_rs2, ex_imm, ex_pc,
        input  ex_wb, ex_mem_rd, ex_mem_wr, dbg_state
    );
endinterface

// File: rtl/instr_decode_stage.sv
// IF/ID + ID/EX decode stage with jump squash and, when ID_LOAD_USE_EN is
// defined, load-use stall/bubble insertion. dbg_state exposes the squash FSM.
module instr_decode_stage #(
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input logic              clk,
    input logic              reset,
    instr_decode_stage_if.slave bus
);
    localparam logic [5:0] OP_ALU  = 6'd1;
    localparam logic [5:0] OP_ADDI = 6'd2;
    localparam logic [5:0] OP_LD   = 6'd3;
    localparam logic [5:0] OP_ST   = 6'd4;
    localparam logic [5:0] OP_JMP  = 6'd5;

    typedef enum logic {ST_RUN, ST_SQUASH} state_t;

    state_t      state;
    state_t      state_next;
    logic        squash;

    logic [31:0] id_ins;
    logic [15:0] id_pc;
    logic        id_valid;

    logic [5:0]  id_op;
    logic [4:0]  id_rd;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [15:0] id_imm;
    logic        legal;
    logic        slot_live;
    logic        hazard;
    logic        jump;

    logic        ex_valid;
    logic [5:0]  ex_op;
    logic [4:0]  ex_rd;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [15:0] ex_imm;
    logic [15:0] ex_pc;
    logic        ex_wb;
    logic        ex_mem_rd;
    logic        ex_mem_wr;

    always_comb begin
        id_op     = id_ins[31:26];
        id_rd     = id_ins[25:21];
        id_rs1    = id_ins[20:16];
        id_rs2    = id_ins[15:11];
        id_imm    = id_ins[15:0];
        legal     = (id_op <= OP_JMP);
        slot_live = id_valid && !squash;
    end

`ifdef ID_LOAD_USE_EN
    logic uses_rs1;
    logic uses_rs2;

    always_comb begin
        uses_rs1 = (id_op == OP_ALU) || (id_op == OP_ADDI) ||
                   (id_op == OP_LD)  || (id_op == OP_ST);
        uses_rs2 = (id_op == OP_ALU) || (id_op == OP_ST);
    end

    // Only the registered ID/EX load can collide; r0 is hard-wired and never waits.
    always_comb begin
        hazard = slot_live && ex_valid && ex_mem_rd && (ex_rd != 5'd0) &&
                 ((uses_rs1 && (ex_rd == id_rs1)) ||
                  (uses_rs2 && (ex_rd == id_rs2)));
    end
`else
    assign hazard = 1'b0;
`endif

    assign jump = slot_live && (id_op == OP_JMP) && !hazard;

    // Squash FSM: ST_SQUASH marks that IF/ID holds the killed wrong-path slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_RUN;
        else        state <= state_next;
    end

    always_comb begin
        state_next = ST_RUN;
        case (state)
            ST_RUN:    state_next = jump ? ST_SQUASH : ST_RUN;
            ST_SQUASH: state_next = ST_RUN;
            default:   state_next = ST_RUN;
        endcase
    end

    always_comb begin
        squash = (state == ST_SQUASH);
    end

    // The sequential word arriving alongside a taken jump is dropped here.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_ins   <= NOP_WORD;
            id_pc    <= 16'h0000;
            id_valid <= 1'b0;
        end else if (hazard) begin
            id_ins   <= id_ins;
            id_pc    <= id_pc;
            id_valid <= id_valid;
        end else if (jump) begin
            id_ins   <= NOP_WORD;
            id_pc    <= 16'h0000;
            id_valid <= 1'b0;
        end else begin
            id_ins   <= bus.ins;
            id_pc    <= bus.pc_in;
            id_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid  <= 1'b0;
            ex_op     <= 6'd0;
            ex_rd     <= 5'd0;
            ex_rs1    <= 5'd0;
            ex_rs2    <= 5'd0;
            ex_imm    <= 16'h0000;
            ex_pc     <= 16'h0000;
            ex_wb     <= 1'b0;
            ex_mem_rd <= 1'b0;
            ex_mem_wr <= 1'b0;
        end else if (hazard || !slot_live || !legal) begin
            ex_valid  <= 1'b0;
            ex_op     <= 6'd0;
            ex_rd     <= 5'd0;
            ex_rs1    <= 5'd0;
            ex_rs2    <= 5'd0;
            ex_imm    <= 16'h0000;
            ex_pc     <= 16'h0000;
            ex_wb     <= 1'b0;
            ex_mem_rd <= 1'b0;
            ex_mem_wr <= 1'b0;
        end else begin
            ex_valid  <= 1'b1;
            ex_op     <= id_op;
            ex_rd     <= id_rd;
            ex_rs1    <= id_rs1;
            ex_rs2    <= id_rs2;
            ex_imm    <= id_imm;
            ex_pc     <= id_pc;
            ex_wb     <= (id_op == OP_ALU) || (id_op == OP_ADDI) || (id_op == OP_LD);
            ex_mem_rd <= (id_op == OP_LD);
            ex_mem_wr <= (id_op == OP_ST);
        end
    end

    assign bus.stall      = hazard;
    assign bus.stall_pm   = hazard;
    assign bus.pc_mux_sel = jump;
    assign bus.jmp_loc    = jump ? id_imm : 16'h0000;
    assign bus.ex_valid   = ex_valid;
    assign bus.ex_op      = ex_op;
    assign bus.ex_rd      = ex_rd;
    assign bus.ex_rs1     = ex_rs1;
    assign bus.ex_rs2     = ex_rs2;
    assign bus.ex_imm     = ex_imm;
    assign bus.ex_pc      = ex_pc;
    assign bus.ex_wb      = ex_wb;
    assign bus.ex_mem_rd  = ex_mem_rd;
    assign bus.ex_mem_wr  = ex_mem_wr;
    assign bus.dbg_state  = squash;
endmodule

// File: tb/tb_instr_decode_stage.sv
// Bench for instr_decode_stage: a fetch model walks small programs, an
// architectural trace of each program fills the expected queue.
module tb_instr_decode_stage;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instr_decode_stage_if bus ();

    instr_decode_stage #(.NOP_WORD(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] prog [0:255];
    logic [15:0] fpc;
    logic [15:0] nxt;
    logic [55:0] exp_q [$];
    logic [15:0] jmp_q [$];
    int checks = 0;
    int failures = 0;
    int exp_stall, exp_bub, exp_jmps;
    int stalls, stall_pms, bubs, jmps;
    bit started;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [55:0] pack(input logic [5:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [15:0] imm, input logic [15:0] pc,
                                         input logic wb, input logic mrd, input logic mwr);
        return {op, rd, rs1, rs2, imm, pc, wb, mrd, mwr};
    endfunction

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [15:0] imm);
        return {op, rd, rs1, imm};
    endfunction

    function automatic logic [15:0] rimm(input logic [4:0] rs2);
        return {rs2, 11'd0};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = 32'h0;
    endtask

    task automatic drive();
        bus.ins   = prog[fpc[7:0]];
        bus.pc_in = fpc;
    endtask

    // Fetch model: hold on stall, redirect on pc_mux_sel, else advance.
    task automatic fetch_edge();
        nxt = bus.stall ? fpc : (bus.pc_mux_sel ? bus.jmp_loc : fpc + 16'd1);
        @(posedge clk);
        #1;
        fpc = nxt;
        drive();
    endtask

    // Architectural walk of the program: issue order, jumps, expected penalties.
    task automatic build_trace(input logic [15:0] start);
        logic [15:0] pc;
        logic [31:0] w;
        logic [5:0]  op;
        logic [4:0]  prev_ld;
        logic        use1, use2;
        int          hz;
        exp_q.delete();
        jmp_q.delete();
        exp_stall = 0; exp_bub = 0; exp_jmps = 0; hz = 0;
        pc = start;
        prev_ld = 5'd0;
        for (int s = 0; s < 64; s++) begin
            w = prog[pc[7:0]];
            if (w == 32'h0) break;
            op = w[31:26];
            if (op > 6'd5) begin
                exp_bub++;
                prev_ld = 5'd0;
                pc = pc + 16'd1;
                continue;
            end
            use1 = (op >= 6'd1) && (op <= 6'd4);
            use2 = (op == 6'd1) || (op == 6'd4);
            if (prev_ld != 5'd0 && ((use1 && w[20:16] == prev_ld) || (use2 && w[15:11] == prev_ld)))
                hz++;
            exp_q.push_back(pack(op, w[25:21], w[20:16], w[15:11], w[15:0], pc,
                                 (op == 6'd1) || (op == 6'd2) || (op == 6'd3),
                                 op == 6'd3, op == 6'd4));
            prev_ld = (op == 6'd3) ? w[25:21] : 5'd0;
            if (op == 6'd5) begin
                jmp_q.push_back(w[15:0]);
                exp_jmps++;
                exp_bub++;
                pc = w[15:0];
            end else begin
                pc = pc + 16'd1;
            end
        end
`ifdef ID_LOAD_USE_EN
        exp_stall = hz;
        exp_bub   = exp_bub + hz;
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ex_valid"}, bus.ex_valid, 1'b0);
        check_eq({tag, "_ex_fields"}, {bus.ex_op, bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.ex_imm, bus.ex_pc}, 53'd0);
        check_eq({tag, "_ex_ctl"}, {bus.ex_wb, bus.ex_mem_rd, bus.ex_mem_wr}, 3'd0);
        check_eq({tag, "_fetch_ctl"}, {bus.stall, bus.stall_pm, bus.pc_mux_sel}, 3'd0);
        check_eq({tag, "_jmp_loc"}, bus.jmp_loc, 16'h0);
        check_eq({tag, "_squash"}, bus.dbg_state, 1'b0);
    endtask

    task automatic sample_cycle();
        if (bus.stall) stalls++;
        if (bus.stall_pm) stall_pms++;
        if (bus.pc_mux_sel) begin
            jmps++;
            if (jmp_q.size() > 0) check_eq("jmp_loc", bus.jmp_loc, jmp_q.pop_front());
        end
        if (bus.ex_valid) begin
            started = 1'b1;
            check_eq("ex_record",
                     pack(bus.ex_op, bus.ex_rd, bus.ex_rs1, bus.ex_rs2, bus.ex_imm, bus.ex_pc,
                          bus.ex_wb, bus.ex_mem_rd, bus.ex_mem_wr),
                     exp_q.pop_front());
        end else if (started) begin
            bubs++;
        end
    endtask

    task automatic run_prog(input string name, input logic [15:0] start);
        int cyc;
        build_trace(start);
        @(negedge clk);
        reset = 1'b0;
        fpc = start;
        drive();
        #1;
        check_reset_outputs({name, "_rst"});
        @(negedge clk);
        reset = 1'b1;
        stalls = 0; stall_pms = 0; bubs = 0; jmps = 0; started = 1'b0;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 200) begin
            sample_cycle();
            if (exp_q.size() == 0) break;
            fetch_edge();
            @(negedge clk);
            cyc++;
        end
        check_eq({name, "_left_in_queue"}, exp_q.size(), 0);
        check_eq({name, "_stalls"}, stalls, exp_stall);
        check_eq({name, "_stall_pm"}, stall_pms, exp_stall);
        check_eq({name, "_bubbles"}, bubs, exp_bub);
        check_eq({name, "_jumps"}, jmps, exp_jmps);
    endtask

    task automatic test_reset_midstream();
        clear_prog();
        prog[0] = enc(6'd3, 5'd4, 5'd1, 16'h0008);
        prog[1] = enc(6'd1, 5'd5, 5'd4, rimm(5'd1));
        prog[2] = enc(6'd2, 5'd6, 5'd1, 16'h0001);
        @(negedge clk);
        reset = 1'b0;
        fpc = 16'h0;
        drive();
        @(negedge clk);
        reset = 1'b1;
        fetch_edge();
        fetch_edge();
        check_eq("mid_ld_in_ex", {bus.ex_valid, bus.ex_mem_rd, bus.ex_rd}, {1'b1, 1'b1, 5'd4});
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("mid");
        fpc = 16'h0;
        drive();
        @(negedge clk);
        reset = 1'b1;
        fetch_edge();
        check_eq("mid_one_edge_ex_valid", bus.ex_valid, 1'b0);
        fetch_edge();
        check_eq("mid_two_edges", {bus.ex_valid, bus.ex_op, bus.ex_rd, bus.ex_pc},
                 {1'b1, 6'd3, 5'd4, 16'h0000});
    endtask

    initial begin
        fpc = 16'h0;
        clear_prog();
        drive();

        test_reset_midstream();

        clear_prog();
        prog[16'h10] = enc(6'd1, 5'd3, 5'd1, rimm(5'd2));
        prog[16'h11] = enc(6'd2, 5'd4, 5'd3, 16'h1234);
        prog[16'h12] = enc(6'd4, 5'd0, 5'd2, rimm(5'd3));
        prog[16'h13] = enc(6'd1, 5'd6, 5'd4, rimm(5'd5));
        run_prog("straight", 16'h0010);

        clear_prog();
        prog[16'h20] = enc(6'd3, 5'd4, 5'd1, 16'h0008);
        prog[16'h21] = enc(6'd1, 5'd5, 5'd4, rimm(5'd1));
        prog[16'h22] = enc(6'd2, 5'd7, 5'd5, 16'h0001);
        run_prog("load_use", 16'h0020);

        clear_prog();
        prog[16'h28] = enc(6'd3, 5'd0, 5'd1, 16'h0004);
        prog[16'h29] = enc(6'd1, 5'd5, 5'd0, rimm(5'd1));
        prog[16'h2A] = enc(6'd3, 5'd4, 5'd2, 16'h0000);
        prog[16'h2B] = enc(6'd2, 5'd6, 5'd1, 16'h2000);
        prog[16'h2C] = enc(6'd3, 5'd9, 5'd2, 16'h0000);
        prog[16'h2D] = enc(6'd4, 5'd0, 5'd3, rimm(5'd9));
        prog[16'h2E] = enc(6'd2, 5'd1, 5'd1, 16'h0002);
        run_prog("r0_imm_rs2", 16'h0028);

        clear_prog();
        prog[16'h08] = enc(6'd5, 5'd0, 5'd0, 16'h0040);
        prog[16'h09] = enc(6'd1, 5'd7, 5'd7, rimm(5'd7));
        prog[16'h40] = enc(6'd2, 5'd1, 5'd2, 16'h0055);
        prog[16'h41] = enc(6'd1, 5'd3, 5'd1, rimm(5'd1));
        run_prog("jump", 16'h0008);

        clear_prog();
        prog[16'h50] = enc(6'd3, 5'd2, 5'd1, 16'h0000);
        prog[16'h51] = enc(6'd1, 5'd6, 5'd2, rimm(5'd3));
        prog[16'h52] = enc(6'd5, 5'd0, 5'd0, 16'h0070);
        prog[16'h53] = enc(6'd3, 5'd6, 5'd6, 16'h0000);
        prog[16'h70] = enc(6'd1, 5'd8, 5'd6, rimm(5'd6));
        prog[16'h71] = enc(6'd2, 5'd9, 5'd8, 16'h0003);
        run_prog("hazard_then_jump", 16'h0050);

        clear_prog();
        prog[16'h80] = enc(6'd1, 5'd1, 5'd2, rimm(5'd3));
        prog[16'h81] = enc(6'h2A, 5'd1, 5'd1, 16'h0000);
        prog[16'h82] = enc(6'd2, 5'd2, 5'd1, 16'h0010);
        run_prog("illegal_op", 16'h0080);

        clear_prog();
        for (int i = 16'h90; i < 16'hA4; i++)
            prog[i] = enc(6'($urandom_range(1, 4)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)),
                          {2'b00, 3'($urandom_range(0, 7)), 11'($urandom_range(0, 2047))});
        prog[16'h9A] = enc(6'd5, 5'd0, 5'd0, 16'h00C0);
        for (int i = 16'hC0; i < 16'hC6; i++)
            prog[i] = enc(6'($urandom_range(1, 4)), 5'($urandom_range(0, 7)),
                          5'($urandom_range(0, 7)),
                          {2'b00, 3'($urandom_range(0, 7)), 11'($urandom_range(0, 2047))});
        run_prog("random", 16'h0090);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
